// File: rtl/stc_commit_if.sv
// Handshake bundle between the STQ_C commit unit and the ROB/LSQ, the reservation table,
// the data-memory port and the writeback path.
interface stc_commit_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned ROB_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [TAG_W-1:0]  req_dest_tag;
    logic [ROB_W-1:0]  req_rob_idx;

    logic              rsv_query_valid;
    logic [ADDR_W-1:0] rsv_query_addr;
    logic              rsv_hit;
    logic              rsv_clear;

    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_req_ready;
    logic              mem_ack;

    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [ROB_W-1:0]  wb_rob_idx;
    logic [DATA_W-1:0] wb_value;

    // The commit unit is the slave of this bundle.
    modport slave (
        input  req_valid, req_addr, req_data, req_dest_tag, req_rob_idx,
        input  rsv_hit, mem_req_ready, mem_ack,
        output req_ready, rsv_query_valid, rsv_query_addr, rsv_clear,
        output mem_req_valid, mem_req_addr, mem_req_data,
        output wb_valid, wb_tag, wb_rob_idx, wb_value
    );

    modport master (
        output req_valid, req_addr, req_data, req_dest_tag, req_rob_idx,
        output rsv_hit, mem_req_ready, mem_ack,
        input  req_ready, rsv_query_valid, rsv_query_addr, rsv_clear,
        input  mem_req_valid, mem_req_addr, mem_req_data,
        input  wb_valid, wb_tag, wb_rob_idx, wb_value
    );
endinterface

// File: rtl/stc_commit_unit.sv
// Memory-side executor for committed STQ_C: consumes the reservation, stores only on a good
// reservation, and writes back 1 (success) or 0 (fail) to the destination register.
module stc_commit_unit #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned ROB_W  = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clock,
    input  logic             reset,
    stc_commit_if.slave      bus,
    output logic [CNT_W-1:0] sc_success_cnt,
    output logic [CNT_W-1:0] sc_fail_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StQuery,
        StDecide,
        StMemReq,
        StWaitAck,
        StWb
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [TAG_W-1:0]  r_tag;
    logic [ROB_W-1:0]  r_rob_idx;
    logic              r_success;
    logic [CNT_W-1:0]  r_success_cnt;
    logic [CNT_W-1:0]  r_fail_cnt;
    logic              w_accept;

    assign w_accept       = (r_state == StIdle) && bus.req_valid;
    assign sc_success_cnt = r_success_cnt;
    assign sc_fail_cnt    = r_fail_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_data        <= '0;
            r_tag         <= '0;
            r_rob_idx     <= '0;
            r_success     <= 1'b0;
            r_success_cnt <= '0;
            r_fail_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr    <= bus.req_addr;
                r_data    <= bus.req_data;
                r_tag     <= bus.req_dest_tag;
                r_rob_idx <= bus.req_rob_idx;
            end
            if (r_state == StDecide) begin
                r_success <= bus.rsv_hit;
            end
            // Counters saturate at all-ones; the writeback itself is never suppressed.
            if (r_state == StWb) begin
                if (r_success) begin
                    if (r_success_cnt != '1) r_success_cnt <= r_success_cnt + CntOne;
                end else begin
                    if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CntOne;
                end
            end
        end
    end

    always_comb begin
        w_state_next        = r_state;
        bus.req_ready       = 1'b0;
        bus.rsv_query_valid = 1'b0;
        bus.rsv_query_addr  = '0;
        bus.rsv_clear       = 1'b0;
        bus.mem_req_valid   = 1'b0;
        bus.mem_req_addr    = '0;
        bus.mem_req_data    = '0;
        bus.wb_valid        = 1'b0;
        bus.wb_tag          = '0;
        bus.wb_rob_idx      = '0;
        bus.wb_value        = '0;

        unique case (r_state)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) w_state_next = StQuery;
            end
            StQuery: begin
                bus.rsv_query_valid = 1'b1;
                bus.rsv_query_addr  = r_addr;
                w_state_next        = StDecide;
            end
            StDecide: begin
                // Every STQ_C consumes the reservation, whether it hit or not.
                bus.rsv_query_addr = r_addr;
                bus.rsv_clear      = 1'b1;
                w_state_next       = bus.rsv_hit ? StMemReq : StWb;
            end
            StMemReq: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = r_addr;
                bus.mem_req_data  = r_data;
                if (bus.mem_req_ready) begin
                    w_state_next = bus.mem_ack ? StWb : StWaitAck;
                end
            end
            StWaitAck: begin
                if (bus.mem_ack) w_state_next = StWb;
            end
            StWb: begin
                bus.wb_valid    = 1'b1;
                bus.wb_tag      = r_tag;
                bus.wb_rob_idx  = r_rob_idx;
                bus.wb_value[0] = r_success;
                w_state_next    = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule

// File: doc/stc_commit_unit.md
Name: stc_commit_unit

Overview:
- Executes committed store-conditional (STQ_C) instructions at the memory end of the LDL/STQ_C protocol.
- The reservation table records and validates reservations. This block consumes them:
  - queries the table for the store address,
  - clears the reservation,
  - issues the store to memory only on a good reservation,
  - writes the architectural result (1 = success, 0 = fail) back to the destination physical register.
- Sits between ROB retirement / LSQ head and the data-memory port. Handles one STQ_C at a time.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, store data / writeback value width
- TAG_W, 6, physical register tag width
- ROB_W, 5, ROB index width
- CNT_W, 32, statistics counter width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  committed STQ_C present
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_W  store address
- req_data  in  DATA_W  store data
- req_dest_tag  in  TAG_W  destination physical register
- req_rob_idx  in  ROB_W  ROB entry of the STQ_C
- rsv_query_valid  out  1  reservation lookup strobe
- rsv_query_addr  out  ADDR_W  lookup address
- rsv_hit  in  1  entry valid, tag match, good=1; valid the cycle after the query
- rsv_clear  out  1  one-cycle pulse: invalidate the entry matching rsv_query_addr
- mem_req_valid  out  1  store request to memory
- mem_req_addr  out  ADDR_W
- mem_req_data  out  DATA_W
- mem_req_ready  in  1  memory accepts the request
- mem_ack  in  1  store completed
- wb_valid  out  1  result writeback strobe
- wb_tag  out  TAG_W
- wb_rob_idx  out  ROB_W
- wb_value  out  DATA_W  1 on success, 0 on fail (zero-extended)
- sc_success_cnt  out  CNT_W  saturating count of successful STQ_C
- sc_fail_cnt  out  CNT_W  saturating count of failed STQ_C

Behaviour:
- Clock and reset: one clock (clock). Reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE.
  - All outputs 0, except req_ready = 1.
  - Both counters 0.
  - Latched request fields 0.
- FSM states: IDLE, QUERY, DECIDE, MEM_REQ, WAIT_ACK, WB.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr/data/tag/rob_idx and go to QUERY.
  - req_ready = 0 in every other state.
- QUERY: rsv_query_valid = 1, rsv_query_addr = latched addr. Go to DECIDE.
- DECIDE:
  - Sample rsv_hit.
  - rsv_clear = 1 for exactly this cycle, hit or miss (any STQ_C consumes the reservation).
  - On hit, latch success = 1 and go to MEM_REQ. On miss, latch success = 0 and go to WB.
  - rsv_query_addr stays at the latched addr through DECIDE.
- MEM_REQ:
  - mem_req_valid = 1; addr/data held stable until mem_req_ready.
  - On mem_req_ready & mem_ack in the same cycle, go directly to WB.
  - On mem_req_ready alone, go to WAIT_ACK.
- WAIT_ACK: mem_req_valid = 0. On mem_ack, go to WB.
- WB:
  - wb_valid = 1 for exactly one cycle, with wb_tag/wb_rob_idx from the latched request and wb_value = success.
  - Increment the matching counter, saturating at all-ones.
  - Go to IDLE.
- Latency, with the request accepted at cycle T:
  - Query at T+1, decide at T+2.
  - Fail path: wb_valid at T+3.
  - Success path with zero memory stall (ready & ack at T+3): wb_valid at T+4.
- Back-to-back operation: the next request is accepted on the cycle after WB (IDLE). Throughput is at most 1 per 4 cycles.
- Boundary conditions:
  - mem_ack outside MEM_REQ/WAIT_ACK is ignored.
  - rsv_hit outside DECIDE is ignored.
  - req_valid outside IDLE is ignored; the producer must hold it.
  - Reset in any state returns to IDLE next cycle. An in-flight store is abandoned with no writeback and no counter change; the memory side is reset with it.
- Counter saturation: at 2^CNT_W-1 the counter holds its value; writeback is still produced.

Test Plan:
1. Reset, then request addr=0x1000, data=0xDEAD, tag=5, rob=3, rsv_hit=1 at T+2, ready+ack at T+3 -> mem_req 0x1000/0xDEAD at T+3; wb_valid at T+4 with tag=5, rob=3, value=1; sc_success_cnt=1; rsv_clear exactly once, at T+2.
2. Same request with rsv_hit=0 -> no mem_req_valid ever; wb at T+3 with value=0; sc_fail_cnt=1; rsv_clear pulsed at T+2.
3. Success path with mem_req_ready low for 3 cycles, then ack 2 cycles after acceptance -> addr/data stable while valid; mem_req_valid drops after acceptance; single wb with value=1.
4. Two back-to-back requests held on req_valid (hit, then miss) -> second accepted the cycle after first WB; results 1 then 0; counters 1/1; req_ready=0 throughout the first request.
5. Reset asserted in WAIT_ACK -> next cycle IDLE with req_ready=1; no wb; counters 0; a late mem_ack is ignored.
6. Preload sc_fail_cnt near max (CNT_W=4 override, 16 fails) -> counter reaches 15 and holds; wb still produced each time.
